// File: rtl/pause_ce_gate.sv
// Gates the CPU clock-enable from a level pause request. Optional macro
// PAUSE_VBLANK_SYNC_EN aligns stop/resume to a vblank rising edge with a timeout.
module pause_ce_gate #(
  parameter int CLKSPD       = 12,
  parameter int CE_DIV       = 4,
  parameter int SYNC_TIMEOUT = CLKSPD * 40000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic pause_cpu,
  input  logic vblank,
  output logic cpu_ce,
  output logic paused
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    ARM_STOP = 2'd1,
    STOPPED  = 2'd2,
    ARM_GO   = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CE_DIV - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] div_cnt;
  logic [7:0] div_nxt;
  logic       running;

  assign running = (state == RUN) || (state == ARM_STOP);

`ifdef PAUSE_VBLANK_SYNC_EN
  localparam logic [31:0] WAIT_LAST = 32'(SYNC_TIMEOUT - 1);

  logic [31:0] wait_cnt;
  logic [31:0] wait_nxt;
  logic        vblank_last;
  logic        vbl_rise;
  logic        tmo;

  assign vbl_rise = vblank & ~vblank_last;
  assign tmo      = (wait_cnt == WAIT_LAST);
`else
  logic unused_sync;
  assign unused_sync = ^{vblank, 32'(SYNC_TIMEOUT)};
`endif

  // Next-state decode; cancellation is checked before vblank/timeout
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
`ifdef PAUSE_VBLANK_SYNC_EN
        if (pause_cpu) state_nxt = ARM_STOP;
`else
        if (pause_cpu) state_nxt = STOPPED;
`endif
      end
      ARM_STOP: begin
`ifdef PAUSE_VBLANK_SYNC_EN
        if (!pause_cpu)           state_nxt = RUN;
        else if (vbl_rise || tmo) state_nxt = STOPPED;
`else
        state_nxt = RUN;
`endif
      end
      STOPPED: begin
`ifdef PAUSE_VBLANK_SYNC_EN
        if (!pause_cpu) state_nxt = ARM_GO;
`else
        if (!pause_cpu) state_nxt = RUN;
`endif
      end
      ARM_GO: begin
`ifdef PAUSE_VBLANK_SYNC_EN
        if (pause_cpu)            state_nxt = STOPPED;
        else if (vbl_rise || tmo) state_nxt = RUN;
`else
        state_nxt = RUN;
`endif
      end
      default: state_nxt = RUN;
    endcase
  end

  // Divider runs only while the CPU is live, so RUN is always entered at zero
  always_comb begin
    div_nxt = 8'd0;
    if (running) begin
      if (div_cnt == DIV_LAST) div_nxt = 8'd0;
      else                     div_nxt = div_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state   <= RUN;
      div_cnt <= 8'd0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
    end
  end

`ifdef PAUSE_VBLANK_SYNC_EN
  // Wait counter never wraps: reaching WAIT_LAST always forces a state change
  always_comb begin
    wait_nxt = 32'd0;
    if ((state_nxt == state) && ((state == ARM_STOP) || (state == ARM_GO)))
      wait_nxt = wait_cnt + 32'd1;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wait_cnt    <= 32'd0;
      vblank_last <= 1'b0;
    end else begin
      wait_cnt    <= wait_nxt;
      vblank_last <= vblank;
    end
  end
`endif

  assign cpu_ce = running && (div_cnt == DIV_LAST);
  assign paused = (state == STOPPED) || (state == ARM_GO);

endmodule
